// File: rtl/bbpd_loop_filter.sv
// Bang-bang phase detector with decimating PI loop filter.
// Stage 1 slices edge/data samples and registers an early/late vote per accepted UI.
// Stage 2 accumulates decim votes, then updates a saturating integrator and the
// proportional+integral output code.
module bbpd_loop_filter #(
  parameter int unsigned sig_bits  = 8,
  parameter int unsigned out_bits  = 10,
  parameter int unsigned decim     = 4,
  parameter int unsigned kp_shift  = 2,
  parameter int unsigned ki_shift  = 0,
  parameter int          init_code = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [sig_bits-1:0] data_samp,
  input  logic signed [sig_bits-1:0] edge_samp,
  input  logic                       freeze,
  output logic signed [out_bits-1:0] out_code,
  output logic                       out_valid,
  output logic                       sat_flag
);

  localparam int unsigned sum_w  = $clog2(decim) + 2;
  localparam int unsigned cnt_w  = $clog2(decim + 1);
  localparam int unsigned max_sh = (kp_shift > ki_shift) ? kp_shift : ki_shift;
  localparam int unsigned iw     = out_bits + $clog2(decim) + max_sh + 2;

  localparam logic signed [iw-1:0] rail_hi = iw'((1 << (out_bits - 1)) - 1);
  localparam logic signed [iw-1:0] rail_lo = iw'(-(1 << (out_bits - 1)));
  localparam logic signed [out_bits-1:0] hi_n = out_bits'(rail_hi);
  localparam logic signed [out_bits-1:0] lo_n = out_bits'(rail_lo);
  localparam logic signed [out_bits-1:0] init_val = out_bits'(init_code);
  localparam logic init_rail = (init_val == hi_n) || (init_val == lo_n);

  // Clamp a wide intermediate to the signed output range.
  function automatic logic signed [out_bits-1:0] sat(input logic signed [iw-1:0] x);
    if (x > rail_hi)      sat = hi_n;
    else if (x < rail_lo) sat = lo_n;
    else                  sat = out_bits'(x);
  endfunction

  logic                       accept;
  logic                       d_bit;
  logic                       e_bit;
  logic signed [1:0]          vote_c;
  logic                       p_bit;
  logic                       p_valid;
  logic                       vote_valid;
  logic signed [1:0]          vote;

  logic signed [sum_w-1:0]    sum;
  logic [cnt_w-1:0]           cnt;
  logic signed [out_bits-1:0] integ;

  logic signed [sum_w-1:0]    sum_acc;
  logic [cnt_w-1:0]           cnt_inc;
  logic                       close;
  logic signed [iw-1:0]       integ_wide;
  logic signed [out_bits-1:0] integ_new;
  logic signed [iw-1:0]       code_wide;
  logic signed [out_bits-1:0] code_new;
  logic                       sat_c;

  // Sign slicing and Alexander-style vote for the current UI.
  always_comb begin
    accept = in_valid && !freeze;
    d_bit  = (data_samp >= sig_bits'(0));
    e_bit  = (edge_samp >= sig_bits'(0));
    vote_c = 2'sd0;
    if (p_valid && (p_bit != d_bit)) begin
      if (e_bit == d_bit) vote_c = 2'sd1;
      else                vote_c = -2'sd1;
    end
  end

  // Stage 1: register the vote and remember the current data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_bit      <= 1'b0;
      p_valid    <= 1'b0;
      vote_valid <= 1'b0;
      vote       <= 2'sd0;
    end else begin
      vote_valid <= accept;
      if (accept) begin
        vote    <= vote_c;
        p_bit   <= d_bit;
        p_valid <= 1'b1;
      end
    end
  end

  // Block accumulation and PI update arithmetic.
  always_comb begin
    sum_acc    = sum + sum_w'(vote);
    cnt_inc    = cnt_w'(cnt + 1'b1);
    close      = vote_valid && (cnt_inc == cnt_w'(decim));
    integ_wide = iw'(integ) + (iw'(sum_acc) <<< ki_shift);
    integ_new  = sat(integ_wide);
    code_wide  = iw'(integ_new) + (iw'(sum_acc) <<< kp_shift);
    code_new   = sat(code_wide);
    sat_c      = (integ_new == hi_n) || (integ_new == lo_n);
  end

  // Stage 2: accumulate votes; on block close update integrator and output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cnt       <= '0;
      integ     <= init_val;
      out_code  <= init_val;
      out_valid <= 1'b0;
      sat_flag  <= init_rail;
    end else begin
      out_valid <= close;
      if (vote_valid) begin
        if (close) begin
          integ    <= integ_new;
          out_code <= code_new;
          sat_flag <= sat_c;
          sum      <= '0;
          cnt      <= '0;
        end else begin
          sum <= sum_acc;
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_bbpd_loop_filter.sv
// Directed bench for bbpd_loop_filter with default parameters.
module tb_bbpd_loop_filter;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic signed [7:0] data_samp = '0;
  logic signed [7:0] edge_samp = '0;
  logic              freeze = 1'b0;
  logic signed [9:0] out_code;
  logic              out_valid;
  logic              sat_flag;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit last_pos = 1'b0;

  bbpd_loop_filter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data_samp (data_samp),
    .edge_samp (edge_samp),
    .freeze    (freeze),
    .out_code  (out_code),
    .out_valid (out_valid),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  // Count out_valid pulses, sampled mid-cycle.
  always @(negedge clk) if (out_valid === 1'b1) pulses++;

  // Drive one cycle of inputs, return 1ns after the capturing edge.
  task automatic ui(input bit v, input bit f, input int d, input int e);
    @(negedge clk);
    in_valid  = v;
    freeze    = f;
    data_samp = 8'(d);
    edge_samp = 8'(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    freeze   = 1'b0;
  endtask

  task automatic idle();
    ui(1'b0, 1'b0, 0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 pulses = 0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_code !== 10'sd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", out_code); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat_flag); end
    @(negedge clk);
    rst_n = 1'b1;
    #1 pulses = 0;
  endtask

  task automatic test_late();
    apply_reset();
    ui(1, 0, 20, 20); ui(1, 0, -20, -20); ui(1, 0, 20, 20); ui(1, 0, -20, -20);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL late_early_valid: got %b expected 0", out_valid); end
    idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL late_valid1: got %b expected 1", out_valid); end
    checks++; if (out_code !== 10'sd15) begin errors++; $display("FAIL late_code1: got %0d expected 15", out_code); end
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL late_pulse_end: got %b expected 0", out_valid); end
    checks++; if (out_code !== 10'sd15) begin errors++; $display("FAIL late_hold: got %0d expected 15", out_code); end
    ui(1, 0, 20, 20); ui(1, 0, -20, -20); ui(1, 0, 20, 20); ui(1, 0, -20, -20);
    idle();
    checks++; if (out_code !== 10'sd23) begin errors++; $display("FAIL late_code2: got %0d expected 23", out_code); end
    idle();
    checks++; if (pulses !== 2) begin errors++; $display("FAIL late_pulses: got %0d expected 2", pulses); end
  endtask

  task automatic test_no_transitions();
    apply_reset();
    ui(1, 0, -20, -20); ui(1, 0, 20, 20); ui(1, 0, -20, -20); ui(1, 0, 20, 20);
    idle();
    checks++; if (out_code !== 10'sd15) begin errors++; $display("FAIL flat_setup: got %0d expected 15", out_code); end
    for (int i = 0; i < 4; i++) ui(1, 0, 0, 0);
    idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flat_valid: got %b expected 1", out_valid); end
    checks++; if (out_code !== 10'sd3) begin errors++; $display("FAIL flat_code1: got %0d expected 3", out_code); end
    for (int i = 0; i < 4; i++) ui(1, 0, 0, 0);
    idle(); idle();
    checks++; if (out_code !== 10'sd3) begin errors++; $display("FAIL flat_code2: got %0d expected 3", out_code); end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL flat_pulses: got %0d expected 3", pulses); end
  endtask

  task automatic test_saturation();
    int d;
    apply_reset();
    last_pos = 1'b0;
    for (int i = 0; i < 560; i++) begin
      d = last_pos ? -20 : 20;
      ui(1, 0, d, d);
      last_pos = (d > 0);
    end
    idle();
    checks++; if (out_code !== 10'sd511) begin errors++; $display("FAIL sat_hi_code: got %0d expected 511", out_code); end
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_hi_flag: got %b expected 1", sat_flag); end
    for (int i = 0; i < 4; i++) begin
      d = last_pos ? -20 : 20;
      ui(1, 0, d, -d);
      last_pos = (d > 0);
    end
    idle();
    checks++; if (out_code !== 10'sd491) begin errors++; $display("FAIL sat_leave_code: got %0d expected 491", out_code); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_leave_flag: got %b expected 0", sat_flag); end
    apply_reset();
    last_pos = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = last_pos ? -20 : 20;
      ui(1, 0, d, -d);
      last_pos = (d > 0);
    end
    idle();
    checks++; if (out_code !== -10'sd15) begin errors++; $display("FAIL early_code1: got %0d expected -15", out_code); end
    for (int i = 0; i < 556; i++) begin
      d = last_pos ? -20 : 20;
      ui(1, 0, d, -d);
      last_pos = (d > 0);
    end
    idle();
    checks++; if (out_code !== -10'sd512) begin errors++; $display("FAIL sat_lo_code: got %0d expected -512", out_code); end
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_lo_flag: got %b expected 1", sat_flag); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_code !== 10'sd0) begin errors++; $display("FAIL async_code: got %0d expected 0", out_code); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL async_sat: got %b expected 0", sat_flag); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_gaps_freeze();
    apply_reset();
    ui(1, 0, 20, 20);
    idle();
    ui(1, 1, -20, 20);
    ui(1, 0, -20, -20);
    idle(); idle();
    ui(1, 0, 20, 20);
    ui(1, 1, -20, -20);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_no_early_close: got %b expected 0", out_valid); end
    ui(1, 0, -20, -20);
    idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b expected 1", out_valid); end
    checks++; if (out_code !== 10'sd15) begin errors++; $display("FAIL gap_code: got %0d expected 15", out_code); end
    idle();
    checks++; if (pulses !== 1) begin errors++; $display("FAIL gap_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_reset_mid_block();
    apply_reset();
    ui(1, 0, 20, 20); ui(1, 0, -20, -20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_code !== 10'sd0) begin errors++; $display("FAIL mid_rst_code: got %0d expected 0", out_code); end
    @(negedge clk);
    rst_n = 1'b1;
    #1 pulses = 0;
    ui(1, 0, 20, 20); ui(1, 0, -20, -20);
    idle(); idle();
    checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_no_valid: got %0d pulses expected 0", pulses); end
    ui(1, 0, 20, 20); ui(1, 0, -20, -20);
    idle();
    checks++; if (out_code !== 10'sd15) begin errors++; $display("FAIL mid_code: got %0d expected 15", out_code); end
    idle();
    checks++; if (pulses !== 1) begin errors++; $display("FAIL mid_pulses: got %0d expected 1", pulses); end
  endtask

  initial begin
    test_reset();
    test_late();
    test_no_transitions();
    test_saturation();
    test_gaps_freeze();
    test_reset_mid_block();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
